// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the EX/MEM destination slots, picks ALU
// forwarding sources, and drives stall/flush for load-use, redirects and slow memory.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        id_use_imm,
   input  logic [4:0]  id_rd,
   input  logic        id_reg_write,
   input  logic [1:0]  id_reg_src,
   input  logic        id_mem_access,
   input  logic [1:0]  ex_pc_src,
   input  logic        dmem_ready,
   output logic        stall_if,
   output logic        stall_id,
   output logic        flush_id,
   output logic        flush_ex,
   output logic [1:0]  fwd_a,
   output logic [1:0]  fwd_b,
   output logic [1:0]  state,
   output logic [15:0] stall_cycles
);

   localparam logic [1:0] FWD_IMM    = 2'b00;
   localparam logic [1:0] FWD_MEM    = 2'b01;
   localparam logic [1:0] FWD_EX     = 2'b10;
   localparam logic [1:0] FWD_REG    = 2'b11;
   localparam logic [1:0] PCSRC_PC4  = 2'b00;
   localparam logic [1:0] REGSRC_MEM = 2'b01;

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
      logic       mem_access;
   } slot_t;

   typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;

   state_t state_q, state_d;
   slot_t  exs, mems, id_slot;
   logic   frozen, redirect, load_use, bubble;
   logic [1:0] fa_d, fb_d;

   assign state = state_q;

   function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                          input slot_t ex, input slot_t mem);
      if (!use_rs || rs == 5'd0)             return FWD_REG;
      else if (ex.reg_write && ex.rd == rs)   return FWD_EX;
      else if (mem.reg_write && mem.rd == rs) return FWD_MEM;
      else                                    return FWD_REG;
   endfunction

   always_comb begin
      id_slot = '{rd: id_rd, reg_write: id_reg_write,
                  is_load: (id_reg_src == REGSRC_MEM), mem_access: id_mem_access};
      frozen   = mems.mem_access && !dmem_ready;
      redirect = (ex_pc_src != PCSRC_PC4);
      load_use = exs.is_load && (exs.rd != 5'd0) &&
                 ((id_use_rs1 && id_rs1 == exs.rd) ||
                  (id_use_rs2 && !id_use_imm && id_rs2 == exs.rd));
      fa_d = fwd_sel(id_use_rs1, id_rs1, exs, mems);
      fb_d = id_use_imm ? FWD_IMM : fwd_sel(id_use_rs2, id_rs2, exs, mems);
   end

   // Redirect outranks load-use: the dependent instruction is wrong-path anyway.
   always_comb begin
      stall_if = 1'b0;
      stall_id = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      bubble   = 1'b0;
      state_d  = RUN;
      if (frozen) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         state_d  = MEM_WAIT;
      end else if (redirect) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
         bubble   = 1'b1;
      end else if (load_use) begin
         stall_if = 1'b1;
         stall_id = 1'b1;
         flush_ex = 1'b1;
         bubble   = 1'b1;
         state_d  = LOAD_STALL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         exs          <= '0;
         mems         <= '0;
         fwd_a        <= FWD_REG;
         fwd_b        <= FWD_REG;
         stall_cycles <= '0;
      end else begin
         state_q <= state_d;
         if (stall_if && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
         // While frozen the whole back end holds, so a pending redirect stays visible.
         if (!frozen) begin
            mems  <= exs;
            exs   <= bubble ? '0 : id_slot;
            fwd_a <= bubble ? FWD_REG : fa_d;
            fwd_b <= bubble ? FWD_REG : fb_d;
         end
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

   localparam logic [1:0] IMM = 2'b00, MEM = 2'b01, EX = 2'b10, REG = 2'b11;
   localparam logic [1:0] PC4 = 2'b00, BRANCH = 2'b01, JUMP = 2'b10;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       use1, use2, use_imm, rw, mem;
      logic [1:0] reg_src;
   } instr_t;

   typedef struct {
      string       name;
      logic [27:0] v;   // {stall_if,stall_id,flush_id,flush_ex,fwd_a,fwd_b,state,stall_cycles}
   } exp_t;

   logic        clk = 1'b0, reset = 1'b1;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_use_imm = 1'b0;
   logic        id_reg_write = 1'b0, id_mem_access = 1'b0, dmem_ready = 1'b1;
   logic [1:0]  id_reg_src = '0, ex_pc_src = '0;
   logic        stall_if, stall_id, flush_id, flush_ex;
   logic [1:0]  fwd_a, fwd_b, state;
   logic [15:0] stall_cycles;

   exp_t q[$];
   int   checks = 0, passed = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_write(id_reg_write),
      .id_reg_src(id_reg_src), .id_mem_access(id_mem_access), .ex_pc_src(ex_pc_src),
      .dmem_ready(dmem_ready), .stall_if(stall_if), .stall_id(stall_id),
      .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .state(state), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic instr_t mk_i(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                   logic u1, logic u2, logic ui, logic rw,
                                   logic [1:0] src, logic mem);
      instr_t i;
      i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.use1 = u1; i.use2 = u2; i.use_imm = ui;
      i.rw = rw; i.reg_src = src; i.mem = mem;
      return i;
   endfunction

   function automatic instr_t nop();                         return mk_i(0, 0, 0, 0, 0, 0, 0, 2'b00, 0); endfunction
   function automatic instr_t add(logic [4:0] d, a, b);      return mk_i(d, a, b, 1, 1, 0, 1, 2'b00, 0); endfunction
   function automatic instr_t addi(logic [4:0] d, a, b);     return mk_i(d, a, b, 1, 1, 1, 1, 2'b00, 0); endfunction
   function automatic instr_t lw(logic [4:0] d, a);          return mk_i(d, a, 0, 1, 0, 1, 1, 2'b01, 1); endfunction
   function automatic instr_t sw(logic [4:0] a, b);          return mk_i(0, a, b, 1, 1, 1, 0, 2'b00, 1); endfunction
   function automatic instr_t beq(logic [4:0] a, b);         return mk_i(0, a, b, 1, 1, 0, 0, 2'b00, 0); endfunction

   task automatic drive(input instr_t i, input logic [1:0] pcs, input logic rdy,
                        input string name, input logic [3:0] sf, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [1:0] st, input logic [15:0] sc);
      exp_t e;
      id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
      id_use_rs1 = i.use1; id_use_rs2 = i.use2; id_use_imm = i.use_imm;
      id_reg_write = i.rw; id_reg_src = i.reg_src; id_mem_access = i.mem;
      ex_pc_src = pcs; dmem_ready = rdy;
      e.name = name;
      e.v = {sf, fa, fb, st, sc};
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [27:0] act;
         e = q.pop_front();
         act = {stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, state, stall_cycles};
         checks++;
         if (act === e.v) passed++;
         else $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
   end

   initial begin
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      drive(nop(),         PC4, 1, "reset",          4'b0000, REG, REG, 0, 0);
      // ALU-to-ALU forwarding
      drive(add(5, 1, 2),  PC4, 1, "s1_add_x5",      4'b0000, REG, REG, 0, 0);
      drive(add(6, 5, 5),  PC4, 1, "s1_issue",       4'b0000, REG, REG, 0, 0);
      drive(nop(),         PC4, 1, "s1_fwd_ex",      4'b0000, EX,  EX,  0, 0);
      drive(nop(),         PC4, 1, "s1_drain",       4'b0000, REG, REG, 0, 0);
      // load-use: one stall, then forward from MEM
      drive(lw(7, 1),      PC4, 1, "s2_lw",          4'b0000, REG, REG, 0, 0);
      drive(add(8, 7, 0),  PC4, 1, "s2_loaduse",     4'b1101, REG, IMM, 0, 0);
      drive(add(8, 7, 0),  PC4, 1, "s2_stall_state", 4'b0000, REG, REG, 1, 1);
      drive(nop(),         PC4, 1, "s2_fwd_mem",     4'b0000, MEM, REG, 0, 1);
      drive(nop(),         PC4, 1, "s2_drain",       4'b0000, REG, REG, 0, 1);
      // x0 never forwards; immediate overrides an rs2 match
      drive(addi(0, 1, 0), PC4, 1, "s3_addi_x0",     4'b0000, REG, REG, 0, 1);
      drive(add(10, 0, 0), PC4, 1, "s3_x0_rd_issue", 4'b0000, REG, IMM, 0, 1);
      drive(addi(9, 5, 10),PC4, 1, "s3_x0_reader",   4'b0000, REG, REG, 0, 1);
      drive(nop(),         PC4, 1, "s3_imm",         4'b0000, REG, IMM, 0, 1);
      drive(nop(),         PC4, 1, "s3_drain",       4'b0000, REG, REG, 0, 1);
      do_reset();
      // store stuck in MEM while a branch waits in EX
      drive(sw(1, 2),      PC4,    1, "s4_sw",       4'b0000, REG, REG, 0, 0);
      drive(beq(3, 4),     PC4,    1, "s4_beq",      4'b0000, REG, IMM, 0, 0);
      drive(add(11, 1, 2), BRANCH, 0, "s4_frz1",     4'b1100, REG, REG, 0, 0);
      drive(add(11, 1, 2), BRANCH, 0, "s4_frz2",     4'b1100, REG, REG, 2, 1);
      drive(add(11, 1, 2), BRANCH, 0, "s4_frz3",     4'b1100, REG, REG, 2, 2);
      drive(add(11, 1, 2), BRANCH, 1, "s4_flush",    4'b0011, REG, REG, 2, 3);
      drive(nop(),         PC4,    1, "s4_after",    4'b0000, REG, REG, 0, 3);
      drive(nop(),         PC4,    1, "s4_drain",    4'b0000, REG, REG, 0, 3);
      // redirect wins over load-use
      drive(lw(7, 1),      PC4,  1, "s5_lw",         4'b0000, REG, REG, 0, 3);
      drive(add(8, 7, 0),  JUMP, 1, "s5_jump_lu",    4'b0011, REG, IMM, 0, 3);
      drive(nop(),         PC4,  1, "s5_after",      4'b0000, REG, REG, 0, 3);
      drive(nop(),         PC4,  1, "s5_drain",      4'b0000, REG, REG, 0, 3);
      // reset while in MEM_WAIT
      drive(sw(1, 2),      PC4, 1, "s6_sw",          4'b0000, REG, REG, 0, 3);
      drive(nop(),         PC4, 1, "s6_sw_ex",       4'b0000, REG, IMM, 0, 3);
      drive(add(12, 1, 2), PC4, 0, "s6_frz1",        4'b1100, REG, REG, 0, 3);
      drive(add(12, 1, 2), PC4, 0, "s6_frz2",        4'b1100, REG, REG, 2, 4);
      do_reset();
      drive(nop(),         PC4, 1, "s6_after_rst",   4'b0000, REG, REG, 0, 0);
      drive(nop(),         PC4, 0, "s6_slots_clear", 4'b0000, REG, REG, 0, 0);
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
